// File: rtl/tt_um_uart_rx.sv
// 8N1 UART receiver for Tiny Tapeout: serial rx on ui_in[0], byte on uo_out,
// sticky status flags on uio_out[4:0], flags cleared by a rising edge on ui_in[1].
module tt_um_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s1_q, rx_s2_q;
  logic             ack_s1_q, ack_s2_q, ack_s3_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ready_q, overrun_q, frame_err_q;
  logic             good_stop, bad_stop, ack_evt, busy;

  logic unused;
  assign unused = ^{uio_in, ui_in[7:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
    end else begin
      rx_s1_q  <= ui_in[0];
      rx_s2_q  <= rx_s1_q;
      ack_s1_q <= ui_in[1];
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
    end
  end

  // Flags are retained while disabled, so acks are ignored too.
  assign ack_evt = ena & ack_s2_q & ~ack_s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (!ena) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_s2_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_d = '0;
            if (!rx_s2_q) begin
              state_d = StData;
              idx_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            shift_d = {rx_s2_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_d     = '0;
            state_d   = StIdle;
            good_stop = rx_s2_q;
            bad_stop  = ~rx_s2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // A byte landing with the ack wins over it; overrun only counts an unacked byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q <= good_stop;
      if (good_stop) begin
        data_q <= shift_q;
      end
      if (good_stop) begin
        ready_q <= 1'b1;
      end else if (ack_evt) begin
        ready_q <= 1'b0;
      end
      if (ack_evt) begin
        overrun_q <= 1'b0;
      end else if (good_stop && ready_q) begin
        overrun_q <= 1'b1;
      end
      if (bad_stop) begin
        frame_err_q <= 1'b1;
      end else if (ack_evt) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign uo_out  = data_q;
  assign uio_out = {3'b000, busy, frame_err_q, overrun_q, ready_q, valid_q};
  assign uio_oe  = 8'b0001_1111;

endmodule

// File: tb/tb_tt_um_uart_rx.sv
// Bench for tt_um_uart_rx: directed scenarios plus random frames, checked against a
// frame-level model of the received byte and sticky flags.
module tb_tt_um_uart_rx;

  localparam int CPB   = 8;
  localparam int FRAME = 10 * CPB;
  localparam int TAIL  = 8;
  // Ack driven on this frame cycle reaches the edge detector on the stop-sample edge.
  localparam int ACK_SAME = CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n, ena, rx, ack;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  assign ui_in = {6'b0, ack, rx};

  tt_um_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_data;
  logic       m_dr, m_ov, m_fe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, " uo_out"}, {24'b0, uo_out}, {24'b0, m_data});
    check_eq({tag, " uio_out"}, {24'b0, uio_out}, {27'b0, m_fe, m_ov, m_dr, 1'b0});
  endtask

  // Drives one frame on rx; cut_at >= 0 interrupts it with reset or ena=0 for 3 cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at,
                            input int cut_at, input bit cut_rst);
    logic [9:0] bits;
    int  vcnt;
    bit  cut;
    int  exp_valid;
    bits = {stop, b, 1'b0};
    vcnt = 0;
    cut  = 1'b0;
    for (int c = 0; c < FRAME + TAIL; c++) begin
      @(negedge clk);
      if (uio_out[0] === 1'b1) vcnt++;
      if (c == 40 && !cut) check_eq("busy_mid_frame", {31'b0, uio_out[4]}, 32'd1);
      if (cut_at >= 0 && c == cut_at) begin
        cut = 1'b1;
        if (cut_rst) rst_n = 1'b0;
        else ena = 1'b0;
      end
      if (cut_rst && cut_at >= 0 && c == cut_at + 2) begin
        check_eq("in_reset uo_out", {24'b0, uo_out}, 32'd0);
        check_eq("in_reset uio_out", {24'b0, uio_out}, 32'd0);
        check_eq("in_reset uio_oe", {24'b0, uio_oe}, 32'h1f);
      end
      if (cut_at >= 0 && c == cut_at + 3) begin
        rst_n = 1'b1;
        ena   = 1'b1;
      end
      if (ack_at >= 0 && c == ack_at) ack = 1'b1;
      if (c == FRAME + TAIL / 2) ack = 1'b0;
      rx = (cut || c >= FRAME) ? 1'b1 : bits[c / CPB];
    end
    exp_valid = 0;
    if (cut_at >= 0) begin
      if (cut_rst) begin
        m_data = 8'h00;
        m_dr   = 1'b0;
        m_ov   = 1'b0;
        m_fe   = 1'b0;
      end
    end else begin
      if (ack_at >= 0) begin
        m_dr = 1'b0;
        m_ov = 1'b0;
        m_fe = 1'b0;
      end
      if (stop) begin
        if (m_dr) m_ov = 1'b1;
        m_dr      = 1'b1;
        m_data    = b;
        exp_valid = 1;
      end else begin
        m_fe = 1'b1;
      end
    end
    check_eq($sformatf("valid_pulses(%02h)", b), vcnt, exp_valid);
    check_outputs($sformatf("after_frame(%02h)", b));
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    repeat (5) @(negedge clk);
    ack = 1'b0;
    repeat (5) @(negedge clk);
    m_dr = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
    check_outputs("after_ack");
  endtask

  task automatic glitch();
    int vcnt;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (uio_out[0] === 1'b1) vcnt++;
      if (c == 4) check_eq("glitch busy", {31'b0, uio_out[4]}, 32'd1);
      rx = (c < 2) ? 1'b0 : 1'b1;
    end
    check_eq("glitch valid_pulses", vcnt, 0);
    check_outputs("after_glitch");
  endtask

  initial begin
    int sel, ack_at;
    logic [7:0] b;
    logic stop;
    rx     = 1'b1;
    ack    = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    m_data = 8'h00;
    m_dr   = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check_eq("reset uio_oe", {24'b0, uio_oe}, 32'h1f);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
    send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
    send_frame(8'h81, 1'b1, -1, -1, 1'b0);
    pulse_ack();
    send_frame(8'h55, 1'b0, -1, -1, 1'b0);
    pulse_ack();
    glitch();
    send_frame(8'hFF, 1'b1, -1, 44, 1'b1);
    send_frame(8'h12, 1'b1, -1, -1, 1'b0);
    send_frame(8'h33, 1'b1, -1, -1, 1'b0);
    send_frame(8'h7E, 1'b1, ACK_SAME, -1, 1'b0);
    send_frame(8'hC3, 1'b1, -1, 30, 1'b0);
    send_frame(8'h42, 1'b1, -1, -1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      b      = 8'($urandom);
      stop   = ($urandom_range(0, 4) != 0);
      sel    = $urandom_range(0, 3);
      ack_at = (sel == 0) ? $urandom_range(10, 60) : (sel == 1) ? ACK_SAME : -1;
      send_frame(b, stop, ack_at, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
